// File: rtl/rx_bit_sampler.sv
// rx_bit_sampler: UART receive front end.
// Synchronizes RxD, validates the start bit, and majority-votes three samples
// per bit using the 4x oversampling tick. It emits one strobed bit per payload
// bit and flags a low stop bit as a framing error.
module rx_bit_sampler #(
  parameter int unsigned DATA_BITS = 9  // payload bits per frame, 1..16
) (
  input  logic clk,
  input  logic rst,        // asynchronous, active-low
  input  logic Baud4Tick,  // one-cycle pulse, four per bit period
  input  logic RxD,        // raw serial line, idle high
  output logic get_inp,    // one-cycle strobe: rxd_bit holds a new payload bit
  output logic rxd_bit,    // majority-voted bit, held between strobes
  output logic busy,       // high from accepted start edge until back in IDLE
  output logic frame_err   // one-cycle pulse: stop bit sampled low
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_e;

  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

  // Two-flop synchronizer, both stages idle high so reset does not look like a start edge.
  logic rxd_meta_q;
  logic rxd_s_q;

  // Synchronize the asynchronous serial line into the clk domain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value; blocking here would collapse the two stages.
      rxd_meta_q <= RxD;
      rxd_s_q    <= rxd_meta_q;
    end
  end

  state_e     state_q;
  logic [1:0] phase_q;
  logic [3:0] bit_cnt_q;
  logic       s0_q, s1_q, s2_q;
  logic       get_inp_q;
  logic       rxd_bit_q;
  logic       busy_q;
  logic       frame_err_q;

  // Third vote input: the live synchronized line during the phase-2 tick,
  // so the decision lands on the same edge that captures s2.
  logic s2_d;
  logic vote;

  assign s2_d = (phase_q == 2'd2) ? rxd_s_q : s2_q;
  assign vote = (s0_q & s1_q) | (s0_q & s2_d) | (s1_q & s2_d);

  // Receive FSM: all activity gated by Baud4Tick, outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      phase_q     <= 2'd0;
      bit_cnt_q   <= 4'd0;
      // NOTE: the sample registers are ordinary flops, not a memory, and are
      // reset to the idle line level so a stale vote can never read as a start.
      s0_q        <= 1'b1;
      s1_q        <= 1'b1;
      s2_q        <= 1'b1;
      get_inp_q   <= 1'b0;
      rxd_bit_q   <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      // Strobes default low so each is exactly one cycle wide.
      get_inp_q   <= 1'b0;
      frame_err_q <= 1'b0;

      if (Baud4Tick) begin
        case (state_q)
          ST_IDLE: begin
            if (!rxd_s_q) begin
              s0_q    <= rxd_s_q;
              phase_q <= 2'd1;
              busy_q  <= 1'b1;
              state_q <= ST_START;
            end
          end

          ST_START: begin
            case (phase_q)
              2'd0: begin
                s0_q    <= rxd_s_q;
                phase_q <= 2'd1;
              end
              2'd1: begin
                s1_q    <= rxd_s_q;
                phase_q <= 2'd2;
              end
              2'd2: begin
                s2_q <= s2_d;
                if (vote) begin
                  // Start bit did not hold low: treat as noise.
                  phase_q <= 2'd0;
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
                end else begin
                  phase_q <= 2'd3;
                end
              end
              default: begin
                phase_q   <= 2'd0;
                bit_cnt_q <= 4'd0;
                state_q   <= ST_DATA;
              end
            endcase
          end

          ST_DATA: begin
            case (phase_q)
              2'd0: begin
                s0_q    <= rxd_s_q;
                phase_q <= 2'd1;
              end
              2'd1: begin
                s1_q    <= rxd_s_q;
                phase_q <= 2'd2;
              end
              2'd2: begin
                s2_q      <= s2_d;
                rxd_bit_q <= vote;
                get_inp_q <= 1'b1;
                phase_q   <= 2'd3;
              end
              default: begin
                phase_q <= 2'd0;
                if (bit_cnt_q == LAST_BIT) begin
                  state_q <= ST_STOP;
                end else begin
                  bit_cnt_q <= bit_cnt_q + 4'd1;
                end
              end
            endcase
          end

          ST_STOP: begin
            case (phase_q)
              2'd0: begin
                s0_q    <= rxd_s_q;
                phase_q <= 2'd1;
              end
              2'd1: begin
                s1_q    <= rxd_s_q;
                phase_q <= 2'd2;
              end
              2'd2: begin
                // Leave early so the last quarter-bit can carry the next start edge.
                s2_q    <= s2_d;
                phase_q <= 2'd0;
                if (vote) begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
                end else begin
                  frame_err_q <= 1'b1;
                  state_q     <= ST_BREAK;
                end
              end
              default: begin
                phase_q <= 2'd0;
              end
            endcase
          end

          ST_BREAK: begin
            // Wait out a held-low line before hunting for a new start edge.
            if (rxd_s_q) begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end

          default: begin
            phase_q <= 2'd0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign get_inp   = get_inp_q;
  assign rxd_bit   = rxd_bit_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_rx_bit_sampler.sv
// Testbench for rx_bit_sampler: scoreboard of expected payload bits and
// framing errors, pushed as frames are driven and popped on each strobe.
module tb_rx_bit_sampler;

  logic clk;
  logic rst;
  logic Baud4Tick;
  logic RxD;
  logic get_inp;
  logic rxd_bit;
  logic busy;
  logic frame_err;

  int checks = 0;
  int errors = 0;

  logic exp_q[$];
  logic ferr_q[$];

  rx_bit_sampler #(.DATA_BITS(9)) dut (
    .clk       (clk),
    .rst       (rst),
    .Baud4Tick (Baud4Tick),
    .RxD       (RxD),
    .get_inp   (get_inp),
    .rxd_bit   (rxd_bit),
    .busy      (busy),
    .frame_err (frame_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Tick every 8 clk, driven on the falling edge.
  initial begin
    Baud4Tick = 1'b0;
    forever begin
      repeat (7) @(negedge clk);
      Baud4Tick = 1'b1;
      @(negedge clk);
      Baud4Tick = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard monitor: sample outputs away from the rising edge.
  always @(negedge clk) begin
    if (get_inp === 1'b1) begin
      if (exp_q.size() == 0) check("spurious_strobe", get_inp, 1'b0);
      else check("rxd_bit", rxd_bit, exp_q.pop_front());
    end
    if (frame_err === 1'b1) begin
      if (ferr_q.size() == 0) check("spurious_frame_err", frame_err, 1'b0);
      else check("frame_err", frame_err, ferr_q.pop_front());
    end
  end

  // Return just after the rising edge that sampled a tick.
  task automatic tick_done();
    @(posedge clk iff Baud4Tick);
    #1;
  endtask

  task automatic idle(input int n);
    RxD = 1'b1;
    repeat (n) tick_done();
  endtask

  // Drive one frame aligned to ticks; glitch_bit inverts that bit's phase-1 sample.
  task automatic send_frame(input logic [15:0] data, input logic stop_val,
                            input int stop_ticks, input int glitch_bit);
    RxD = 1'b0;
    tick_done();
    check("busy_start", busy, 1'b1);
    repeat (3) tick_done();
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(data[i]);
      RxD = data[i];
      tick_done();
      if (i == glitch_bit) RxD = ~data[i];
      tick_done();
      RxD = data[i];
      repeat (2) tick_done();
    end
    RxD = stop_val;
    if (stop_val) begin
      repeat (2) tick_done();
      check("busy_before_stop2", busy, 1'b1);
      tick_done();
      check("busy_fall", busy, 1'b0);
      repeat (stop_ticks - 3) tick_done();
    end else begin
      ferr_q.push_back(1'b1);
      repeat (stop_ticks) tick_done();
      check("busy_break", busy, 1'b1);
    end
    check("strobes_drained", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    rst = 1'b0;
    RxD = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check("rst_get_inp", get_inp, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_rxd_bit", rxd_bit, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    idle(4);
    check("idle_busy", busy, 1'b0);

    // Normal frame.
    send_frame(16'h01A5, 1'b1, 4, -1);
    idle(3);

    // False start: line low for one tick period only.
    RxD = 1'b0;
    tick_done();
    check("fs_busy_t0", busy, 1'b1);
    RxD = 1'b1;
    tick_done();
    check("fs_busy_t1", busy, 1'b1);
    tick_done();
    check("fs_busy_t2", busy, 1'b0);
    idle(2);
    send_frame(16'h00C3, 1'b1, 4, -1);
    idle(2);

    // Glitch on bit 3 phase 1.
    send_frame(16'h00FF, 1'b1, 4, 3);
    idle(2);

    // Framing error: stop low for three bit periods.
    send_frame(16'h0055, 1'b0, 12, -1);
    check("ferr_drained", ferr_q.size(), 0);
    RxD = 1'b1;
    tick_done();
    check("break_exit_busy", busy, 1'b0);
    idle(3);
    send_frame(16'h012A, 1'b1, 4, -1);
    idle(2);

    // Back-to-back with a one-bit stop and no idle gap.
    send_frame(16'h01FF, 1'b1, 4, -1);
    send_frame(16'h0000, 1'b1, 4, -1);
    idle(2);

    // Reset during bit 4 of the data phase.
    d = 16'h00FF;
    RxD = 1'b0;
    repeat (4) tick_done();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(d[i]);
      RxD = d[i];
      repeat (4) tick_done();
    end
    RxD = d[4];
    repeat (2) tick_done();
    check("pre_rst_busy", busy, 1'b1);
    check("pre_rst_rxd_bit", rxd_bit, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_get_inp", get_inp, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_frame_err", frame_err, 1'b0);
    check("mid_rst_rxd_bit", rxd_bit, 1'b0);
    RxD = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    idle(16);
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_no_strobes", exp_q.size(), 0);
    send_frame(16'h0155, 1'b1, 4, -1);
    idle(2);
    check("final_ferr_drained", ferr_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
